// File: rtl/weighted_tally_seq.sv
// Weighted switch tally: sync + debounce four switches, then scan them
// through one shared adder and latch a saturated 3-bit result on LEDs.
module weighted_tally_seq #(
   parameter int unsigned DEB_CYCLES = 4,
   parameter logic [1:0]  W1 = 2'd2,
   parameter logic [1:0]  W2 = 2'd1,
   parameter logic [1:0]  W3 = 2'd2,
   parameter logic [1:0]  W4 = 2'd1
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic SW1,
   input  logic SW2,
   input  logic SW3,
   input  logic SW4,
   output logic LED0,
   output logic LED1,
   output logic LED2,
   output logic VALID,
   output logic BUSY
);

   localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, LATCH} state_t;

   logic [3:0]    sync1;
   logic [3:0]    sv;
   logic [3:0]    sv_prev;
   logic [3:0]    d;
   logic [3:0]    snap;
   logic [3:0]    acc;
   logic [3:0]    addend;
   logic [CW-1:0] cnt;
   logic [2:0]    result;
   logic          stable;
   logic          upd;
   logic          go;
   logic          pend;
   logic          valid;
   state_t        state;
   state_t        state_n;

   assign stable = (sv != d) && (sv == sv_prev);
   assign upd    = stable && (cnt == CNT_MAX);
   assign go     = (state == IDLE) && pend;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1   <= '0;
         sv      <= '0;
         sv_prev <= '0;
         d       <= '0;
         cnt     <= '0;
      end else begin
         sync1   <= ~{SW4, SW3, SW2, SW1};
         sv      <= sync1;
         sv_prev <= sv;
         if (upd) begin
            d   <= sv;
            cnt <= '0;
         end else if (stable) begin
            cnt <= cnt + CW'(1);
         end else begin
            cnt <= '0;
         end
      end
   end

   // Only the addend is muxed per state; one adder serves all switches.
   always_comb begin
      state_n = state;
      addend  = '0;
      case (state)
         IDLE: if (pend) state_n = S1;
         S1: begin
            state_n = S2;
            addend  = snap[0] ? {2'b00, W1} : 4'd0;
         end
         S2: begin
            state_n = S3;
            addend  = snap[1] ? {2'b00, W2} : 4'd0;
         end
         S3: begin
            state_n = S4;
            addend  = snap[2] ? {2'b00, W3} : 4'd0;
         end
         S4: begin
            state_n = LATCH;
            addend  = snap[3] ? {2'b00, W4} : 4'd0;
         end
         LATCH:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= IDLE;
         acc    <= '0;
         snap   <= '0;
         result <= '0;
         pend   <= 1'b1;
         valid  <= 1'b0;
      end else begin
         state <= state_n;
         // An update that lands mid-scan waits for the next IDLE.
         pend  <= upd | (pend & ~go);
         if (go) begin
            snap <= d;
            acc  <= '0;
         end else begin
            acc <= acc + addend;
         end
         if (state == LATCH) begin
            result <= (acc > 4'd7) ? 3'd7 : acc[2:0];
            valid  <= 1'b1;
         end
      end
   end

   assign {LED2, LED1, LED0} = ~result;
   assign VALID = valid;
   assign BUSY  = (state != IDLE);

endmodule
